// File: rtl/riscv_ctrl_pkg.sv
// Shared types and encodings for the multicycle RISC-V control FSM.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    MEMADR,
    MEMREAD,
    MEMWB,
    MEMWRITE,
    EXECUTER,
    EXECUTEI,
    JAL,
    ALUWB,
    BEQ
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Datapath control word produced for each state.
  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // True for the opcodes this controller knows how to sequence.
  function automatic logic op_legal(input logic [6:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
           (op == OP_I) || (op == OP_BEQ) || (op == OP_JAL);
  endfunction

  // Immediate format follows directly from the opcode.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Maps the current FSM state plus the memory-ready and zero flags onto the
// datapath control word. Purely combinational.
module ctrl_out_decode
  import riscv_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  input  logic   zero,
  output ctrl_t  ctrl
);

  // One control word per state; anything not set stays zero.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.adr_src    = 1'b0;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALURESULT;
        ctrl.ir_write   = mem_ready;
        ctrl.pc_write   = mem_ready;
      end
      DECODE: begin
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMADR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      MEMREAD: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
      end
      MEMWB: begin
        ctrl.result_src = RES_DATA;
        ctrl.reg_write  = 1'b1;
      end
      MEMWRITE: begin
        ctrl.adr_src    = 1'b1;
        ctrl.result_src = RES_ALUOUT;
        ctrl.mem_write  = 1'b1;
      end
      EXECUTER: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      EXECUTEI: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      JAL: begin
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.alu_op     = ALUOP_ADD;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = 1'b1;
      end
      ALUWB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_write  = 1'b1;
      end
      BEQ: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_op     = ALUOP_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_write   = zero;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the shared-memory multicycle RISC-V datapath. Holds the
// state register, next-state logic and the retired-instruction counter;
// the per-state control word comes from ctrl_out_decode.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             RegWrite,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_retired
);

  state_t state;
  state_t dec_state;
  ctrl_t  ctrl;

  // While reset is held the selects show FETCH values regardless of the
  // register contents, and every strobe below is gated off so an aborted
  // instruction cannot write anything.
  assign dec_state = reset ? FETCH : state;

  ctrl_out_decode u_decode (
    .state     (dec_state),
    .mem_ready (mem_ready),
    .zero      (zero),
    .ctrl      (ctrl)
  );

  assign PCWrite    = ctrl.pc_write  & ~reset;
  assign IRWrite    = ctrl.ir_write  & ~reset;
  assign MemWrite   = ctrl.mem_write & ~reset;
  assign RegWrite   = ctrl.reg_write & ~reset;
  assign AdrSrc     = ctrl.adr_src;
  assign ResultSrc  = ctrl.result_src;
  assign ALUSrcA    = ctrl.alu_src_a;
  assign ALUSrcB    = ctrl.alu_src_b;
  assign ALUOp      = ctrl.alu_op;
  assign ImmSrc     = imm_src_for(op);
  assign illegal_op = ~reset & (state == DECODE) & ~op_legal(op);

  // State register, next-state selection and retirement counting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FETCH;
      instr_retired <= '0;
    end else begin
      case (state)
        FETCH:    if (mem_ready) state <= DECODE;
        DECODE: begin
          case (op)
            OP_LW, OP_SW: state <= MEMADR;
            OP_R:         state <= EXECUTER;
            OP_I:         state <= EXECUTEI;
            OP_BEQ:       state <= BEQ;
            OP_JAL:       state <= JAL;
            default:      state <= FETCH;
          endcase
        end
        MEMADR:   state <= (op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:  if (mem_ready) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWRITE: if (mem_ready) state <= FETCH;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        JAL:      state <= ALUWB;
        ALUWB:    state <= FETCH;
        BEQ:      state <= FETCH;
        default:  state <= FETCH;
      endcase
      if ((state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
          ((state == MEMWRITE) && mem_ready))
        instr_retired <= instr_retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// cycle by cycle and compares the full control word against hand-derived
// values.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        zero;
  logic        mem_ready;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal_op;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
  logic [31:0] instr_retired;

  int errors = 0;
  int checks = 0;

  // Word layout: {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite, ResultSrc,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [12:0] W_FETCH_R = 13'b10010_10001000;
  localparam logic [12:0] W_FETCH_W = 13'b00000_10001000;
  localparam logic [12:0] W_RESET   = 13'b00000_10001000;
  localparam logic [12:0] W_DECODE  = 13'b00000_00010100;
  localparam logic [12:0] W_MEMADR  = 13'b00000_00100100;
  localparam logic [12:0] W_MEMREAD = 13'b01000_00000000;
  localparam logic [12:0] W_MEMWB   = 13'b00001_01000000;
  localparam logic [12:0] W_MEMWR   = 13'b01100_00000000;
  localparam logic [12:0] W_EXECR   = 13'b00000_00100010;
  localparam logic [12:0] W_EXECI   = 13'b00000_00100110;
  localparam logic [12:0] W_JAL     = 13'b10000_00011000;
  localparam logic [12:0] W_ALUWB   = 13'b00001_00000000;
  localparam logic [12:0] W_BEQ_T   = 13'b10000_00100001;
  localparam logic [12:0] W_BEQ_N   = 13'b00000_00100001;

  multicycle_controller #(.CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .op            (op),
    .zero          (zero),
    .mem_ready     (mem_ready),
    .PCWrite       (PCWrite),
    .AdrSrc        (AdrSrc),
    .MemWrite      (MemWrite),
    .IRWrite       (IRWrite),
    .ResultSrc     (ResultSrc),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUOp         (ALUOp),
    .ImmSrc        (ImmSrc),
    .RegWrite      (RegWrite),
    .illegal_op    (illegal_op),
    .instr_retired (instr_retired)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Compare the control word and illegal_op flag at the current point.
  task automatic check_output(input string tag, input logic [12:0] exp_word, input logic exp_ill);
    logic [12:0] obs;
    obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp};
    checks++;
    assert (obs === exp_word) else begin
      errors++;
      $error("[TB] FAIL %s word observed=%b expected=%b", tag, obs, exp_word);
    end
    checks++;
    assert (illegal_op === exp_ill) else begin
      errors++;
      $error("[TB] FAIL %s illegal_op observed=%b expected=%b", tag, illegal_op, exp_ill);
    end
  endtask

  // Compare the retired-instruction counter.
  task automatic check_count(input string tag, input logic [31:0] exp_cnt);
    checks++;
    assert (instr_retired === exp_cnt) else begin
      errors++;
      $error("[TB] FAIL %s instr_retired observed=%0d expected=%0d", tag, instr_retired, exp_cnt);
    end
  endtask

  // Compare the immediate format select.
  task automatic check_imm(input string tag, input logic [1:0] exp_imm);
    checks++;
    assert (ImmSrc === exp_imm) else begin
      errors++;
      $error("[TB] FAIL %s ImmSrc observed=%b expected=%b", tag, ImmSrc, exp_imm);
    end
  endtask

  // Drive one cycle's inputs, check the settled outputs, advance one clock.
  task automatic apply_stimulus(input string tag, input logic rdy, input logic z,
                                input logic [12:0] exp_word, input logic exp_ill);
    mem_ready = rdy;
    zero      = z;
    #1;
    check_output(tag, exp_word, exp_ill);
    @(posedge clk);
    #1;
  endtask

  // Linear directed sequence.
  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    zero      = 1'b0;
    op        = 7'b0110011;
    #1;
    check_output("reset_async_view", W_RESET, 1'b0);
    @(posedge clk); #1;
    check_output("reset_cycle1", W_RESET, 1'b0);
    check_count("reset_cnt", 32'd0);
    @(posedge clk); #1;
    check_output("reset_cycle2", W_RESET, 1'b0);
    reset = 1'b0;

    // R-type
    op = 7'b0110011;
    apply_stimulus("r_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    check_imm("r_imm", 2'b00);
    apply_stimulus("r_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("r_exec",   1'b1, 1'b0, W_EXECR,   1'b0);
    apply_stimulus("r_aluwb",  1'b1, 1'b0, W_ALUWB,   1'b0);
    check_count("r_cnt", 32'd1);

    // I-type
    op = 7'b0010011;
    apply_stimulus("i_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    apply_stimulus("i_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("i_exec",   1'b1, 1'b0, W_EXECI,   1'b0);
    apply_stimulus("i_aluwb",  1'b1, 1'b0, W_ALUWB,   1'b0);
    check_count("i_cnt", 32'd2);

    // lw with two wait cycles in MEMREAD: 7 cycles
    op = 7'b0000011;
    apply_stimulus("lw_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    apply_stimulus("lw_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("lw_memadr", 1'b1, 1'b0, W_MEMADR,  1'b0);
    apply_stimulus("lw_rd_w0",  1'b0, 1'b0, W_MEMREAD, 1'b0);
    apply_stimulus("lw_rd_w1",  1'b0, 1'b0, W_MEMREAD, 1'b0);
    apply_stimulus("lw_rd_ok",  1'b1, 1'b0, W_MEMREAD, 1'b0);
    apply_stimulus("lw_memwb",  1'b1, 1'b0, W_MEMWB,   1'b0);
    check_output("lw_back_fetch", W_FETCH_R, 1'b0);
    check_count("lw_cnt", 32'd3);

    // sw with three wait cycles in MEMWRITE: MemWrite high four cycles
    op = 7'b0100011;
    apply_stimulus("sw_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    check_imm("sw_imm", 2'b01);
    apply_stimulus("sw_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("sw_memadr", 1'b1, 1'b0, W_MEMADR,  1'b0);
    apply_stimulus("sw_wr_w0",  1'b0, 1'b0, W_MEMWR,   1'b0);
    apply_stimulus("sw_wr_w1",  1'b0, 1'b0, W_MEMWR,   1'b0);
    apply_stimulus("sw_wr_w2",  1'b0, 1'b0, W_MEMWR,   1'b0);
    check_count("sw_cnt_wait", 32'd3);
    apply_stimulus("sw_wr_ok",  1'b1, 1'b0, W_MEMWR,   1'b0);
    check_count("sw_cnt", 32'd4);

    // beq taken and not taken
    op = 7'b1100011;
    apply_stimulus("beq1_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    check_imm("beq_imm", 2'b10);
    apply_stimulus("beq1_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("beq1_taken",  1'b1, 1'b1, W_BEQ_T,   1'b0);
    check_count("beq1_cnt", 32'd5);
    apply_stimulus("beq0_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    apply_stimulus("beq0_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("beq0_not",    1'b1, 1'b0, W_BEQ_N,   1'b0);
    check_count("beq0_cnt", 32'd6);

    // jal
    op = 7'b1101111;
    apply_stimulus("jal_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    check_imm("jal_imm", 2'b11);
    apply_stimulus("jal_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("jal_jal",    1'b1, 1'b0, W_JAL,     1'b0);
    apply_stimulus("jal_aluwb",  1'b1, 1'b0, W_ALUWB,   1'b0);
    check_count("jal_cnt", 32'd7);

    // Illegal opcode after a fetch stall
    op = 7'b1111111;
    apply_stimulus("ill_fetch_w", 1'b0, 1'b0, W_FETCH_W, 1'b0);
    apply_stimulus("ill_fetch",   1'b1, 1'b0, W_FETCH_R, 1'b0);
    apply_stimulus("ill_decode",  1'b1, 1'b0, W_DECODE,  1'b1);
    check_output("ill_back_fetch", W_FETCH_R, 1'b0);
    check_count("ill_cnt", 32'd7);

    // Reset in the middle of a store wait
    op = 7'b0100011;
    apply_stimulus("rst_fetch",  1'b1, 1'b0, W_FETCH_R, 1'b0);
    apply_stimulus("rst_decode", 1'b1, 1'b0, W_DECODE,  1'b0);
    apply_stimulus("rst_memadr", 1'b1, 1'b0, W_MEMADR,  1'b0);
    apply_stimulus("rst_wr_w0",  1'b0, 1'b0, W_MEMWR,   1'b0);
    reset = 1'b1;
    apply_stimulus("rst_in_memwr", 1'b0, 1'b0, W_RESET, 1'b0);
    reset = 1'b0;
    check_count("rst_cnt", 32'd0);
    apply_stimulus("rst_after_fetch", 1'b1, 1'b0, W_FETCH_R, 1'b0);
    check_output("rst_then_decode", W_DECODE, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
